// File: rtl/sp1_mem_arb_pkg.sv
// Shared types and constants for the sp1_ram arbiter.
// Owner encoding and the fixed read-return latency.
package sp1_mem_arb_pkg;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    localparam int MEMARB_RLAT = 2;

endpackage

// File: rtl/sp1_rr_arb2.sv
// Two-way round-robin grant with priority pointer; optional ownership lock
// when SP1_MEMARB_LOCK_EN is defined.
module sp1_rr_arb2
    import sp1_mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic b_req,
    input  logic a_lock,
    input  logic b_lock,
    output logic a_gnt,
    output logic b_gnt
);

    owner_e prio_q, prio_d;
    logic   win_b;
    logic   locked;

`ifdef SP1_MEMARB_LOCK_EN
    logic   lock_q, lock_d;
    owner_e lown_q, lown_d;
    assign locked = lock_q;
`else
    logic   unused_lock;
    assign unused_lock = a_lock ^ b_lock;
    assign locked      = 1'b0;
`endif

    always_comb begin
        win_b = (a_req && b_req) ? (prio_q == OWN_B) : b_req;
        a_gnt = !rst && a_req && !win_b;
        b_gnt = !rst && b_req && win_b;
`ifdef SP1_MEMARB_LOCK_EN
        // While owned, only the owner may be granted.
        if (lock_q) begin
            a_gnt = !rst && a_req && (lown_q == OWN_A);
            b_gnt = !rst && b_req && (lown_q == OWN_B);
        end
`endif
        prio_d = prio_q;
        if ((a_gnt || b_gnt) && !locked)
            prio_d = b_gnt ? OWN_A : OWN_B;
`ifdef SP1_MEMARB_LOCK_EN
        lock_d = lock_q;
        lown_d = lown_q;
        if (a_gnt || b_gnt) begin
            lock_d = b_gnt ? b_lock : a_lock;
            lown_d = b_gnt ? OWN_B : OWN_A;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= OWN_A;
`ifdef SP1_MEMARB_LOCK_EN
            lock_q <= 1'b0;
            lown_q <= OWN_A;
`endif
        end else begin
            prio_q <= prio_d;
`ifdef SP1_MEMARB_LOCK_EN
            lock_q <= lock_d;
            lown_q <= lown_d;
`endif
        end
    end

endmodule

// File: rtl/sp1_mem_arb.sv
// Arbiter + registered command stage for sp1_ram with tagged read return.
// Optional ownership lock: define SP1_MEMARB_LOCK_EN.
module sp1_mem_arb
    import sp1_mem_arb_pkg::*;
#(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_adr,
    input  logic [DW-1:0] a_din,
    input  logic          a_lock,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_adr,
    input  logic [DW-1:0] b_din,
    input  logic          b_lock,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_adr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    logic                   ram_we_q, ram_we_d;
    logic [AW-1:0]          ram_adr_q, ram_adr_d;
    logic [DW-1:0]          ram_din_q, ram_din_d;
    logic                   ram_cs_q;
    logic [MEMARB_RLAT:1]   vld_pipe_q, vld_pipe_d;
    logic [MEMARB_RLAT:1]   own_pipe_q, own_pipe_d;
    logic                   accept;

    sp1_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .a_req  (a_req),
        .b_req  (b_req),
        .a_lock (a_lock),
        .b_lock (b_lock),
        .a_gnt  (a_gnt),
        .b_gnt  (b_gnt)
    );

    assign accept = a_gnt || b_gnt;

    always_comb begin
        // Idle cycles become a harmless read of the last address.
        ram_we_d  = 1'b0;
        ram_adr_d = ram_adr_q;
        ram_din_d = ram_din_q;
        if (accept) begin
            ram_we_d  = b_gnt ? b_we  : a_we;
            ram_adr_d = b_gnt ? b_adr : a_adr;
            ram_din_d = b_gnt ? b_din : a_din;
        end
        vld_pipe_d    = vld_pipe_q << 1;
        own_pipe_d    = own_pipe_q << 1;
        vld_pipe_d[1] = accept && !ram_we_d;
        own_pipe_d[1] = b_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cs_q   <= 1'b1;
            ram_we_q   <= 1'b0;
            ram_adr_q  <= '0;
            ram_din_q  <= '0;
            vld_pipe_q <= '0;
            own_pipe_q <= '0;
        end else begin
            ram_cs_q   <= 1'b1;
            ram_we_q   <= ram_we_d;
            ram_adr_q  <= ram_adr_d;
            ram_din_q  <= ram_din_d;
            vld_pipe_q <= vld_pipe_d;
            own_pipe_q <= own_pipe_d;
        end
    end

    assign ram_cs   = ram_cs_q;
    assign ram_we   = ram_we_q;
    assign ram_adr  = ram_adr_q;
    assign ram_din  = ram_din_q;
    assign a_rvalid = !rst && vld_pipe_q[MEMARB_RLAT] && (own_pipe_q[MEMARB_RLAT] == OWN_A);
    assign b_rvalid = !rst && vld_pipe_q[MEMARB_RLAT] && (own_pipe_q[MEMARB_RLAT] == OWN_B);
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_sp1_mem_arb.sv
// Bench for sp1_mem_arb: simple RAM, behavioural arbitration/memory model,
// directed scenarios plus randomized traffic.
module tb_sp1_mem_arb;

    localparam int AW = 6;
    localparam int DW = 32;
`ifdef SP1_MEMARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_adr, b_adr;
    logic [DW-1:0] a_din, b_din;
    logic a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] rdata;
    logic ram_cs, ram_we;
    logic [AW-1:0] ram_adr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    always #5 clk = ~clk;

    sp1_mem_arb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_din(a_din), .a_lock(a_lock),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_din(b_din), .b_lock(b_lock),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rdata(rdata), .ram_cs(ram_cs), .ram_we(ram_we), .ram_adr(ram_adr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Synchronous single-port RAM, read-first.
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_cs === 1'b1) ram_dout <= ram_mem[ram_adr];
        if (ram_cs === 1'b1 && ram_we === 1'b1) ram_mem[ram_adr] <= ram_din;
    end

    int n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Model state: shadow memory, priority, lock, expected returns.
    typedef struct { int due; bit own_b; logic [DW-1:0] d; } ret_t;
    ret_t          rq[$];
    logic [DW-1:0] shadow [0:(1<<AW)-1];
    bit            m_prio_b = 0, m_lk = 0, m_own_b = 0;
    logic          e_we = 0;
    logic [AW-1:0] e_adr = '0;
    logic [DW-1:0] e_din = '0;

    bit            o_ga, o_gb, o_arv, o_brv, o_cs, o_we;
    logic [AW-1:0] o_adr;
    bit            h_ga [0:4095], h_gb [0:4095], h_arv [0:4095], h_brv [0:4095];
    logic [DW-1:0] h_rd [0:4095];

    initial for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;

    task automatic set_idle();
        a_req = 0; a_we = 0; a_adr = '0; a_din = '0; a_lock = 0;
        b_req = 0; b_we = 0; b_adr = '0; b_din = '0; b_lock = 0;
    endtask

    task automatic step();
        bit ea, eb, erva, ervb;
        logic [DW-1:0] erd;
        @(negedge clk);
        ea = 0; eb = 0;
        if (!rst) begin
            if (LOCK_EN && m_lk) begin
                ea = a_req && !m_own_b;
                eb = b_req && m_own_b;
            end else if (a_req && b_req) begin
                ea = !m_prio_b; eb = m_prio_b;
            end else begin
                ea = a_req; eb = b_req;
            end
        end
        erva = 0; ervb = 0; erd = '0;
        if (!rst && rq.size() > 0 && rq[0].due == cyc) begin
            erva = !rq[0].own_b; ervb = rq[0].own_b; erd = rq[0].d;
        end
        o_ga = a_gnt; o_gb = b_gnt; o_arv = a_rvalid; o_brv = b_rvalid;
        o_cs = ram_cs; o_we = ram_we; o_adr = ram_adr;
        h_ga[cyc] = a_gnt; h_gb[cyc] = b_gnt; h_arv[cyc] = a_rvalid;
        h_brv[cyc] = b_rvalid; h_rd[cyc] = rdata;
        chk("a_gnt", {31'b0, a_gnt}, {31'b0, ea});
        chk("b_gnt", {31'b0, b_gnt}, {31'b0, eb});
        chk("a_rvalid", {31'b0, a_rvalid}, {31'b0, erva});
        chk("b_rvalid", {31'b0, b_rvalid}, {31'b0, ervb});
        if (erva || ervb) chk("rdata", rdata, erd);
        chk("ram_cs", {31'b0, ram_cs}, 32'd1);
        chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
        chk("ram_adr", {26'b0, ram_adr}, {26'b0, e_adr});
        chk("ram_din", ram_din, e_din);
        // Advance the model to the next cycle.
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (rst) begin
            rq.delete();
            m_prio_b = 0; m_lk = 0; m_own_b = 0;
            e_we = 0; e_adr = '0; e_din = '0;
        end else if (ea || eb) begin
            e_we  = eb ? b_we  : a_we;
            e_adr = eb ? b_adr : a_adr;
            e_din = eb ? b_din : a_din;
            if (e_we) shadow[e_adr] = e_din;
            else      rq.push_back('{cyc + 2, eb, shadow[e_adr]});
            if (!(LOCK_EN && m_lk)) m_prio_b = ea;
            m_lk = LOCK_EN && (eb ? b_lock : a_lock);
            m_own_b = eb;
        end else begin
            e_we = 0;
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        int c;
        rst = 1; set_idle();
        @(posedge clk); #1;
        step(); step();
        rst = 0;
        step(); step(); step();
        chk("idle_cs", {31'b0, o_cs}, 32'd1);
        chk("idle_we", {31'b0, o_we}, 32'd0);
        chk("idle_adr", {26'b0, o_adr}, 32'd0);
        chk("idle_rv", {31'b0, o_arv | o_brv}, 32'd0);

        // Single client write then read of address 5.
        c = cyc;
        a_req = 1; a_we = 1; a_adr = 5; a_din = 32'h12345678; step();
        a_we = 0; step();
        set_idle(); step(); step();
        chk("wr_gnt", {31'b0, h_ga[c]}, 32'd1);
        chk("rd_arv", {31'b0, h_arv[c+3]}, 32'd1);
        chk("rd_data", h_rd[c+3], 32'h12345678);
        chk("rd_brv", {31'b0, h_brv[c+3]}, 32'd0);

        // Preload 0xA1@1 via A, 0xB2@2 via B, then continuous contention.
        a_req = 1; a_we = 1; a_adr = 1; a_din = 32'hA1; step();
        set_idle(); b_req = 1; b_we = 1; b_adr = 2; b_din = 32'hB2; step();
        set_idle(); a_req = 1; a_adr = 1; b_req = 1; b_adr = 2;
        c = cyc;
        for (int i = 0; i < 6; i++) step();
        set_idle(); step(); step();
        for (int i = 0; i < 4; i++) begin
            chk("cont_ga", {31'b0, h_ga[c+i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_gb", {31'b0, h_gb[c+i]}, (i % 2 == 0) ? 32'd0 : 32'd1);
            chk("cont_arv", {31'b0, h_arv[c+i+2]}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_rd", h_rd[c+i+2], (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end

        // Locked read-modify-write by A while B keeps requesting.
        a_req = 1; a_we = 0; a_adr = 3; a_lock = 1; b_req = 1; b_adr = 7; step();
        chk("lk1_ga", {31'b0, o_ga}, 32'd1);
        chk("lk1_gb", {31'b0, o_gb}, 32'd0);
        a_we = 1; a_din = 32'hC0DE0003; a_lock = 0; step();
        chk("lk2_ga", {31'b0, o_ga}, LOCK_EN ? 32'd1 : 32'd0);
        chk("lk2_gb", {31'b0, o_gb}, LOCK_EN ? 32'd0 : 32'd1);
        if (LOCK_EN) a_req = 0;
        step();
        chk("lk3_ga", {31'b0, o_ga}, LOCK_EN ? 32'd0 : 32'd1);
        chk("lk3_gb", {31'b0, o_gb}, LOCK_EN ? 32'd1 : 32'd0);
        set_idle(); step(); step();
        chk("lk_mem3", ram_mem[3], 32'hC0DE0003);

        // Reset asserted the cycle after a read is accepted.
        c = cyc;
        a_req = 1; a_adr = 5; step();
        set_idle(); rst = 1; step();
        rst = 0; step();
        chk("rst_we", {31'b0, o_we}, 32'd0);
        chk("rst_adr", {26'b0, o_adr}, 32'd0);
        step(); step();
        for (int i = 1; i <= 4; i++) chk("rst_noarv", {31'b0, h_arv[c+i]}, 32'd0);
        c = cyc;
        a_req = 1; a_adr = 5; step();
        set_idle(); step(); step();
        chk("post_rst_arv", {31'b0, h_arv[c+2]}, 32'd1);
        chk("post_rst_rd", h_rd[c+2], 32'h12345678);

        // Randomized traffic on a small address window.
        for (int i = 0; i < 1500; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            a_req  = $urandom_range(0, 3) != 0;
            b_req  = $urandom_range(0, 3) != 0;
            a_we   = $urandom_range(0, 1);
            b_we   = $urandom_range(0, 1);
            a_adr  = AW'($urandom_range(0, 7));
            b_adr  = AW'($urandom_range(0, 7));
            a_din  = $urandom;
            b_din  = $urandom;
            a_lock = $urandom_range(0, 3) == 0;
            b_lock = $urandom_range(0, 3) == 0;
            step();
        end
        rst = 0; set_idle(); step(); step(); step();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
